// File: rtl/ethernet_tx.sv
// RMII Ethernet II transmitter: preamble, SFD, header, payload with zero pad,
// CRC-32 FCS and inter-frame gap, emitted LSB-first as dibits on txd/txen.
module ethernet_tx #(
  parameter int unsigned N           = 2,
  parameter int unsigned MIN_PAYLOAD = 46,
  parameter int unsigned IFG_BYTES   = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tx_start,
  input  logic [47:0]  dst_mac,
  input  logic [47:0]  src_mac,
  input  logic [15:0]  ethertype,
  input  logic [7:0]   axiid,
  input  logic         axiiv,
  input  logic         axiil,
  output logic         axiir,
  output logic [N-1:0] txd,
  output logic         txen,
  output logic         tx_busy,
  output logic         tx_done,
  output logic         tx_err
);

  typedef enum logic [2:0] {
    StIdle, StPreamble, StSfd, StHeader, StPayload, StPad, StFcs, StIfg
  } state_e;

  localparam logic [10:0] MinPay  = 11'(MIN_PAYLOAD);
  localparam logic [9:0]  IfgLast = 10'(IFG_BYTES * 4 - 1);
  localparam logic [31:0] CrcPoly = 32'hEDB88320;

  state_e       state_q, state_d;
  logic [1:0]   dibit_q, dibit_d;      // dibit index of the byte currently on the wire
  logic [9:0]   cnt_q, cnt_d;          // byte index within a field, or IFG cycle count
  logic [10:0]  pay_cnt_q, pay_cnt_d;  // payload + pad bytes, saturating
  logic [7:0]   byte_q, byte_d;        // byte currently on the wire
  logic         last_q, last_d;        // current payload byte carried axiil
  logic [111:0] hdr_q, hdr_d;          // header shift register, next byte at the top
  logic [31:0]  fcs_q, fcs_d;          // remaining FCS bytes, next byte at the bottom
  logic [31:0]  crc_q, crc_d;
  logic [1:0]   txd_q, txd_d;
  logic         txen_q, txen_d;
  logic         axiir_q, axiir_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         err_q, err_d;

  logic         byte_end;
  logic         load_req;
  logic         enter_fcs;
  logic [31:0]  crc_upd;
  logic [10:0]  pay_cnt_inc;

  // Reflected CRC-32 advanced by one dibit, bit 0 first.
  function automatic logic [31:0] crc_dibit(input logic [31:0] crc, input logic [1:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 2; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ CrcPoly;
      else             c = c >> 1;
    end
    return c;
  endfunction

  // Next-state, next-byte and registered-output computation for the framer.
  always_comb begin
    state_d   = state_q;
    dibit_d   = dibit_q + 2'd1;
    cnt_d     = cnt_q;
    pay_cnt_d = pay_cnt_q;
    byte_d    = byte_q;
    last_d    = last_q;
    hdr_d     = hdr_q;
    fcs_d     = fcs_q;
    crc_d     = crc_q;
    txen_d    = txen_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    load_req  = 1'b0;
    enter_fcs = 1'b0;
    crc_upd   = crc_dibit(crc_q, txd_q);
    byte_end  = (dibit_q == 2'd3);
    pay_cnt_inc = (pay_cnt_q == 11'h7FF) ? pay_cnt_q : pay_cnt_q + 11'd1;

    unique case (state_q)
      StIdle: begin
        dibit_d = 2'd0;
        crc_d   = 32'hFFFF_FFFF;
        if (tx_start) begin
          state_d   = StPreamble;
          hdr_d     = {dst_mac, src_mac, ethertype};
          byte_d    = 8'h55;
          cnt_d     = '0;
          pay_cnt_d = '0;
          last_d    = 1'b0;
          txen_d    = 1'b1;
          busy_d    = 1'b1;
        end
      end
      StPreamble: begin
        if (byte_end) begin
          if (cnt_q == 10'd6) begin
            state_d = StSfd;
            byte_d  = 8'hD5;
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end
      end
      StSfd: begin
        if (byte_end) begin
          state_d = StHeader;
          cnt_d   = '0;
          byte_d  = hdr_q[111:104];
          hdr_d   = hdr_q << 8;
        end
      end
      StHeader: begin
        crc_d = crc_upd;
        if (byte_end) begin
          if (cnt_q == 10'd13) begin
            load_req = 1'b1;
          end else begin
            cnt_d  = cnt_q + 10'd1;
            byte_d = hdr_q[111:104];
            hdr_d  = hdr_q << 8;
          end
        end
      end
      StPayload: begin
        crc_d = crc_upd;
        if (byte_end) begin
          if (!last_q) begin
            load_req = 1'b1;
          end else if (pay_cnt_q < MinPay) begin
            state_d   = StPad;
            byte_d    = 8'h00;
            pay_cnt_d = pay_cnt_inc;
          end else begin
            enter_fcs = 1'b1;
          end
        end
      end
      StPad: begin
        crc_d = crc_upd;
        if (byte_end) begin
          if (pay_cnt_q < MinPay) begin
            byte_d    = 8'h00;
            pay_cnt_d = pay_cnt_inc;
          end else begin
            enter_fcs = 1'b1;
          end
        end
      end
      StFcs: begin
        if (byte_end) begin
          if (cnt_q == 10'd3) begin
            state_d = StIfg;
            cnt_d   = '0;
            txen_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            cnt_d  = cnt_q + 10'd1;
            byte_d = fcs_q[7:0];
            fcs_d  = fcs_q >> 8;
          end
        end
      end
      StIfg: begin
        dibit_d = 2'd0;
        if (cnt_q == IfgLast) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
    endcase

    // axiir is high in this cycle, so the sampled byte (or its absence) decides the next one.
    if (load_req) begin
      if (axiiv) begin
        state_d   = StPayload;
        byte_d    = axiid;
        last_d    = axiil;
        pay_cnt_d = pay_cnt_inc;
      end else begin
        state_d = StIfg;
        cnt_d   = '0;
        txen_d  = 1'b0;
        err_d   = 1'b1;
      end
    end

    // The CRC must include the dibit on the wire right now.
    if (enter_fcs) begin
      state_d = StFcs;
      cnt_d   = '0;
      byte_d  = ~crc_upd[7:0];
      fcs_d   = {8'h00, ~crc_upd[31:8]};
    end

    axiir_d = txen_d && (dibit_d == 2'd3) &&
              ((state_d == StHeader && cnt_d == 10'd13) || (state_d == StPayload && !last_d));
    txd_d   = txen_d ? byte_d[{dibit_d, 1'b0} +: 2] : 2'b00;
  end

  // State and registered outputs, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      dibit_q   <= '0;
      cnt_q     <= '0;
      pay_cnt_q <= '0;
      byte_q    <= '0;
      last_q    <= 1'b0;
      hdr_q     <= '0;
      fcs_q     <= '0;
      crc_q     <= 32'hFFFF_FFFF;
      txd_q     <= '0;
      txen_q    <= 1'b0;
      axiir_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dibit_q   <= dibit_d;
      cnt_q     <= cnt_d;
      pay_cnt_q <= pay_cnt_d;
      byte_q    <= byte_d;
      last_q    <= last_d;
      hdr_q     <= hdr_d;
      fcs_q     <= fcs_d;
      crc_q     <= crc_d;
      txd_q     <= txd_d;
      txen_q    <= txen_d;
      axiir_q   <= axiir_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign txd     = txd_q;
  assign txen    = txen_q;
  assign axiir   = axiir_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;
  assign tx_err  = err_q;

endmodule

// File: tb/tb_ethernet_tx.sv
// Randomized bench for ethernet_tx: frames are rebuilt from captured dibits and
// compared against byte-level frames built from the Ethernet framing rules.
module tb_ethernet_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_start;
  logic [47:0] dst_mac;
  logic [47:0] src_mac;
  logic [15:0] ethertype;
  logic [7:0]  axiid;
  logic        axiiv;
  logic        axiil;
  logic        axiir;
  logic [1:0]  txd;
  logic        txen;
  logic        tx_busy;
  logic        tx_done;
  logic        tx_err;

  int n_checks  = 0;
  int n_errors  = 0;
  int cyc_g     = 0;
  int last_hi_g = 0;

  always #10 clk = ~clk;

  ethernet_tx dut (
    .clk       (clk),
    .rst       (rst),
    .tx_start  (tx_start),
    .dst_mac   (dst_mac),
    .src_mac   (src_mac),
    .ethertype (ethertype),
    .axiid     (axiid),
    .axiiv     (axiiv),
    .axiil     (axiil),
    .axiir     (axiir),
    .txd       (txd),
    .txen      (txen),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .tx_err    (tx_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Textbook bit-serial reflected CRC-32 over one byte.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc_in, input logic [7:0] b);
    logic [31:0] crc;
    crc = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (crc[0] ^ b[i]) crc = (crc >> 1) ^ 32'hEDB88320;
      else               crc = crc >> 1;
    end
    return crc;
  endfunction

  task automatic idle(input int n);
    int bad;
    bad = 0;
    repeat (n) begin
      @(negedge clk);
      cyc_g++;
      tx_start = 1'b0;
      if (txen !== 1'b0 || txd !== 2'b00) bad++;
      axiiv = 1'($urandom);
      axiid = 8'($urandom);
      axiil = 1'($urandom);
    end
    check("idle_quiet", bad, 0);
  endtask

  // mode: 0 random payload, 1 ramp 0..len-1, 2 fixed header with 0xAB bytes.
  // under >= 0 withholds payload byte 'under' to force an underrun.
  task automatic send_frame(input int len, input int under, input int mode, input bit b2b);
    logic [7:0]  pay[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    logic [1:0]  dib[$];
    logic [47:0] d, s;
    logic [15:0] et;
    logic [31:0] crc;
    int lexp, k, c, nsent, fall, bmis, nmin;
    int txen_cnt, done_cnt, done_cyc, err_cnt, err_cyc, rdy_cnt, rdy_bad, last_rdy, txd_bad;

    if (mode == 2) begin
      d  = 48'hFFFF_FFFF_FFFF;
      s  = 48'h6969_5A06_5491;
      et = 16'h0800;
    end else begin
      d  = {16'($urandom), 32'($urandom)};
      s  = {16'($urandom), 32'($urandom)};
      et = 16'($urandom);
    end
    for (int i = 0; i < len; i++) begin
      if (mode == 1)      pay.push_back(8'(i));
      else if (mode == 2) pay.push_back(8'hAB);
      else                pay.push_back(8'($urandom));
    end

    // Expected wire bytes.
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 5; i >= 0; i--) exp_q.push_back(d[8*i +: 8]);
    for (int i = 5; i >= 0; i--) exp_q.push_back(s[8*i +: 8]);
    exp_q.push_back(et[15:8]);
    exp_q.push_back(et[7:0]);
    nsent = (under < 0) ? len : under;
    for (int i = 0; i < nsent; i++) exp_q.push_back(pay[i]);
    if (under < 0) begin
      for (int i = len; i < 46; i++) exp_q.push_back(8'h00);
      crc = 32'hFFFF_FFFF;
      for (int i = 8; i < exp_q.size(); i++) crc = crc_byte(crc, exp_q[i]);
      crc = ~crc;
      for (int i = 0; i < 4; i++) exp_q.push_back(crc[8*i +: 8]);
      lexp = (8 + 14 + ((len > 46) ? len : 46) + 4) * 4;
    end else begin
      lexp = (8 + 14 + under) * 4;
    end

    tx_start  = 1'b1;
    dst_mac   = d;
    src_mac   = s;
    ethertype = et;
    axiiv     = 1'b0;
    k = 0; c = 0; fall = -1;
    txen_cnt = 0; done_cnt = 0; done_cyc = -1; err_cnt = 0; err_cyc = -1;
    rdy_cnt = 0; rdy_bad = 0; last_rdy = -1; txd_bad = 0;

    while (fall < 0 && c < lexp + 200) begin
      @(negedge clk);
      c++;
      cyc_g++;
      // Starts during the frame, in the IFG and in the last busy cycle must be ignored.
      tx_start = (c == 100 || c == lexp + 20 || c == lexp + 48);
      if (tx_start) dst_mac = {16'($urandom), 32'($urandom)};

      if (c == 1) begin
        check("busy_on", tx_busy, 1);
        check("txen_on", txen, 1);
        if (b2b) check("b2b_gap", cyc_g - last_hi_g - 1, 49);
      end
      if (txen) begin
        dib.push_back(txd);
        txen_cnt++;
        last_hi_g = cyc_g;
      end else if (txd !== 2'b00) begin
        txd_bad++;
      end
      if (tx_done) begin done_cnt++; done_cyc = c; end
      if (tx_err)  begin err_cnt++;  err_cyc  = c; end
      if (axiir) begin
        rdy_cnt++;
        if (last_rdy >= 0 && c - last_rdy != 4) rdy_bad++;
        last_rdy = c;
      end

      if (!tx_busy) begin
        fall = c;
      end else begin
        if (axiir) begin
          if (k == under || k >= len) begin
            axiiv = 1'b0;
          end else begin
            axiiv = 1'b1;
            axiid = pay[k];
            axiil = (k == len - 1);
          end
        end else begin
          axiiv = 1'($urandom);
          axiid = 8'($urandom);
          axiil = 1'($urandom);
        end
        if (axiir && axiiv) k++;
      end
    end
    tx_start = 1'b0;
    axiiv    = 1'b0;

    for (int i = 0; i + 3 < dib.size(); i += 4)
      got_q.push_back({dib[i+3], dib[i+2], dib[i+1], dib[i]});
    nmin = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    bmis = (got_q.size() > exp_q.size()) ? got_q.size() - exp_q.size()
                                         : exp_q.size() - got_q.size();
    for (int i = 0; i < nmin; i++) if (got_q[i] !== exp_q[i]) bmis++;

    check("txen_len", txen_cnt, lexp);
    check("frame_bytes", bmis, 0);
    check("txd_zero_when_idle", txd_bad, 0);
    check("busy_fall", fall, lexp + 49);
    check("axiir_spacing", rdy_bad, 0);
    if (under < 0) begin
      check("done_cnt", done_cnt, 1);
      check("done_cycle", done_cyc, lexp + 1);
      check("err_cnt", err_cnt, 0);
      check("axiir_cnt", rdy_cnt, len);
      crc = 32'hFFFF_FFFF;
      for (int i = 8; i < got_q.size(); i++) crc = crc_byte(crc, got_q[i]);
      check("crc_residue", crc, 32'hDEBB20E3);
    end else begin
      check("err_cnt", err_cnt, 1);
      check("err_cycle", err_cyc, lexp + 1);
      check("done_cnt", done_cnt, 0);
      check("axiir_cnt", rdy_cnt, under + 1);
    end
  endtask

  // Reset asserted during the sixth header byte.
  task automatic reset_mid_header();
    tx_start  = 1'b1;
    dst_mac   = {16'($urandom), 32'($urandom)};
    src_mac   = {16'($urandom), 32'($urandom)};
    ethertype = 16'($urandom);
    axiiv     = 1'b0;
    for (int c = 1; c <= 55; c++) begin
      @(negedge clk);
      cyc_g++;
      tx_start = 1'b0;
      if (c == 54) begin
        check("txen_before_rst", txen, 1);
        rst = 1'b1;
      end
      if (c == 55) begin
        check("rst_txen", txen, 0);
        check("rst_busy", tx_busy, 0);
        check("rst_other_outputs", {txd, axiir, tx_done, tx_err}, 0);
        rst = 1'b0;
      end
    end
  endtask

  initial begin
    int len, under;
    rst = 1'b1;
    tx_start = 1'b0;
    dst_mac = '0;
    src_mac = '0;
    ethertype = '0;
    axiid = '0;
    axiiv = 1'b0;
    axiil = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_txen", txen, 0);
    check("reset_outputs", {txd, axiir, tx_busy, tx_done, tx_err}, 0);
    rst = 1'b0;
    idle(3);

    send_frame(1, -1, 2, 1'b0);
    idle(5);
    send_frame(64, -1, 1, 1'b0);
    idle(4);
    send_frame(20, 10, 0, 1'b0);
    idle(4);
    reset_mid_header();
    idle(5);
    send_frame(50, -1, 0, 1'b0);
    idle(3);
    send_frame(30, -1, 0, 1'b0);
    send_frame(12, -1, 0, 1'b1);

    for (int f = 0; f < 6; f++) begin
      len   = $urandom_range(1, 80);
      under = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
      idle($urandom_range(1, 8));
      send_frame(len, under, 0, 1'b0);
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
